// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS phase accumulator.
// Steps the frequency control word from f_start to f_stop in f_step
// increments. Each value is held for the dwell count, and the sweep can
// run once or repeat continuously. All outputs are registered.
module dds_sweep_ctrl #(
  parameter int WIDE_N  = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [WIDE_N-1:0]  f_start,
  input  logic [WIDE_N-1:0]  f_stop,
  input  logic [WIDE_N-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDE_N-1:0]  fcw_o,
  output logic               acc_clr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               step_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               cont_r;
  logic [WIDE_N-1:0]  f_start_r;
  logic [WIDE_N-1:0]  f_stop_r;
  logic [WIDE_N-1:0]  f_step_r;
  logic [DWELL_W-1:0] dwell_r;   // effective dwell, never zero once latched
  logic [DWELL_W-1:0] cnt;

  // The candidate next FCW carries one extra bit, so an overflow past the
  // top of the FCW range always compares as beyond f_stop and never wraps.
  logic [WIDE_N:0]    nxt;
  logic               dwell_end;
  logic               advance;

  assign nxt       = {1'b0, fcw_o} + {1'b0, f_step_r};
  assign dwell_end = (cnt == dwell_r - 1'b1);
  assign advance   = (f_step_r != '0) && (nxt <= {1'b0, f_stop_r});

  // Sweep sequencer: state, latched configuration, dwell counter and all outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cont_r    <= 1'b0;
      f_start_r <= '0;
      f_stop_r  <= '0;
      f_step_r  <= '0;
      dwell_r   <= '0;
      cnt       <= '0;
      fcw_o     <= '0;
      acc_clr_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      step_o    <= 1'b0;
    end else begin
      // The pulse outputs are high for one cycle only, unless a branch below re-arms them.
      acc_clr_o <= 1'b0;
      done_o    <= 1'b0;
      step_o    <= 1'b0;

      if (abort) begin
        state  <= IDLE;
        fcw_o  <= '0;
        busy_o <= 1'b0;
        cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cont_r    <= cont;
              f_start_r <= f_start;
              f_stop_r  <= f_stop;
              f_step_r  <= f_step;
              dwell_r   <= (dwell == '0) ? DWELL_W'(1) : dwell;
              busy_o    <= 1'b1;
              state     <= LOAD;
            end
          end

          LOAD: begin
            fcw_o     <= f_start_r;
            acc_clr_o <= 1'b1;
            cnt       <= '0;
            state     <= DWELL;
          end

          DWELL: begin
            if (!dwell_end) begin
              cnt <= cnt + 1'b1;
            end else if (advance) begin
              fcw_o  <= nxt[WIDE_N-1:0];
              step_o <= 1'b1;
              cnt    <= '0;
            end else if (cont_r) begin
              fcw_o     <= f_start_r;
              acc_clr_o <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt    <= '0;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end

          DONE: begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
